// File: rtl/ariane_pkg.sv
// Shared core types: exceptions, scoreboard entries, writeback ports.
// Sizing constants for the in-order scoreboard live here.
package ariane_pkg;

  localparam int unsigned NR_SB_ENTRIES = 4;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
  localparam int unsigned NR_WB_PORTS   = 2;

  localparam logic [63:0] INSTR_ADDR_MISALIGNED = 64'd0;
  localparam logic [63:0] INSTR_ACCESS_FAULT    = 64'd1;
  localparam logic [63:0] ILLEGAL_INSTR         = 64'd2;
  localparam logic [63:0] BREAKPOINT            = 64'd3;
  localparam logic [63:0] LD_ADDR_MISALIGNED    = 64'd4;
  localparam logic [63:0] LD_ACCESS_FAULT       = 64'd5;
  localparam logic [63:0] ST_ADDR_MISALIGNED    = 64'd6;
  localparam logic [63:0] ST_ACCESS_FAULT       = 64'd7;

  typedef enum logic [3:0] {
    NONE,
    LOAD,
    STORE,
    ALU,
    CTRL_FLOW,
    MULT,
    CSR
  } fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_t                      fu;
    logic [6:0]               op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    logic                     use_imm;
    exception                 ex;
  } scoreboard_entry;

  typedef struct packed {
    logic                     valid;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [63:0]              wdata;
    exception                 ex;
  } wb_port_t;

  // Advance a ring pointer, wrapping at n slots.
  function automatic logic [TRANS_ID_BITS-1:0] ptr_inc(
    input logic [TRANS_ID_BITS-1:0] p,
    input int unsigned              n
  );
    if (p == TRANS_ID_BITS'(n - 1))
      return '0;
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/scoreboard.sv
// In-order scoreboard ring: decode allocates, FUs write back, commit retires.
// SB_COMMIT_BYPASS_EN: forward head writebacks straight to the commit port.
module scoreboard #(
  parameter int unsigned NR_ENTRIES  = ariane_pkg::NR_SB_ENTRIES,
  parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   flush_i,
  output logic                                   full_o,
  input  ariane_pkg::scoreboard_entry            decoded_instr_i,
  input  logic                                   decoded_instr_valid_i,
  output logic                                   decoded_instr_ack_o,
  output logic [ariane_pkg::TRANS_ID_BITS-1:0]   issued_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                 wb_valid_i,
  input  logic [NR_WB_PORTS-1:0]
               [ariane_pkg::TRANS_ID_BITS-1:0]   trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]           wdata_i,
  input  ariane_pkg::exception [NR_WB_PORTS-1:0] ex_i,
  output ariane_pkg::scoreboard_entry            commit_instr_o,
  output logic                                   commit_valid_o,
  input  logic                                   commit_ack_i
);
  import ariane_pkg::*;

  localparam int unsigned CNT_W = $clog2(NR_ENTRIES + 1);

  typedef logic [TRANS_ID_BITS-1:0] ptr_t;

  scoreboard_entry       mem [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] alloc;
  ptr_t                  rptr;
  ptr_t                  wptr;
  logic [CNT_W-1:0]      count;

  scoreboard_entry head;
  logic            issue;
  logic            retire;

  // Slots are only freed by a registered commit, so full is purely registered.
  assign full_o              = (count == CNT_W'(NR_ENTRIES));
  assign issue               = decoded_instr_valid_i & ~full_o & ~flush_i;
  assign decoded_instr_ack_o = issue;
  assign issued_trans_id_o   = wptr;

  // Head view: stored entry, optionally overlaid with this cycle's writebacks.
  always_comb begin
    head = mem[rptr];
`ifdef SB_COMMIT_BYPASS_EN
    for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
      if (wb_valid_i[p] && alloc[rptr] && (trans_id_i[p] == rptr)) begin
        head.result = wdata_i[p];
        head.valid  = 1'b1;
        if (ex_i[p].valid)
          head.ex = ex_i[p];
      end
    end
`endif
  end

  assign commit_instr_o = head;
  assign commit_valid_o = (count != '0) & head.valid;
  assign retire         = commit_ack_i & commit_valid_o;

  // Ring state: issue at wptr, writeback by id, retire at rptr.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NR_ENTRIES); i++)
        mem[i] <= '0;
      alloc <= '0;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      alloc <= '0;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (issue) begin
        mem[wptr]          <= decoded_instr_i;
        mem[wptr].trans_id <= wptr;
        mem[wptr].valid    <= decoded_instr_i.ex.valid;
        alloc[wptr]        <= 1'b1;
        wptr               <= ptr_inc(wptr, NR_ENTRIES);
      end
      // The slot being issued is still unallocated here, so a same-cycle
      // writeback to it falls through; later ports overwrite earlier ones.
      for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
        if (wb_valid_i[p] && alloc[trans_id_i[p]]) begin
          mem[trans_id_i[p]].result <= wdata_i[p];
          mem[trans_id_i[p]].valid  <= 1'b1;
          if (ex_i[p].valid)
            mem[trans_id_i[p]].ex <= ex_i[p];
        end
      end
      if (retire) begin
        alloc[rptr] <= 1'b0;
        rptr        <= ptr_inc(rptr, NR_ENTRIES);
      end
      case ({issue, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// Directed plus random bench for the scoreboard against a queue model.
// Define SB_COMMIT_BYPASS_EN to exercise the head-forwarding build.
module tb_scoreboard;
  import ariane_pkg::*;

  localparam int N = NR_SB_ENTRIES;
  localparam int P = NR_WB_PORTS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                                rst;
  logic                                flush;
  logic                                full;
  scoreboard_entry                     dinstr;
  logic                                dvalid;
  logic                                ack;
  logic [TRANS_ID_BITS-1:0]            issued;
  logic [P-1:0]                        wbv;
  logic [P-1:0][TRANS_ID_BITS-1:0]     wbid;
  logic [P-1:0][63:0]                  wbd;
  exception [P-1:0]                    wbex;
  scoreboard_entry                     cinstr;
  logic                                cvalid;
  logic                                cack;

  scoreboard dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .flush_i               (flush),
    .full_o                (full),
    .decoded_instr_i       (dinstr),
    .decoded_instr_valid_i (dvalid),
    .decoded_instr_ack_o   (ack),
    .issued_trans_id_o     (issued),
    .wb_valid_i            (wbv),
    .trans_id_i            (wbid),
    .wdata_i               (wbd),
    .ex_i                  (wbex),
    .commit_instr_o        (cinstr),
    .commit_valid_o        (cvalid),
    .commit_ack_i          (cack)
  );

  // Model: program-ordered list of in-flight instructions.
  typedef struct packed {
    logic [1:0]  id;
    logic        done;
    logic [63:0] result;
    logic [63:0] pc;
    logic [63:0] cause;
    logic        exv;
  } m_t;

  m_t q[$];
  int next_id;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic idle();
    flush  = 1'b0;
    dvalid = 1'b0;
    dinstr = '0;
    wbv    = '0;
    wbid   = '0;
    wbd    = '0;
    wbex   = '0;
    cack   = 1'b0;
  endtask

  task automatic set_issue(input logic [63:0] pc, input logic exv,
                           input logic [63:0] cause);
    dinstr          = '0;
    dinstr.pc       = pc;
    dinstr.fu       = ALU;
    dinstr.rd       = 5'($urandom);
    dinstr.result   = {$urandom, $urandom};
    dinstr.valid    = 1'($urandom);
    dinstr.trans_id = TRANS_ID_BITS'($urandom);
    dinstr.ex.valid = exv;
    dinstr.ex.cause = cause;
    dvalid          = 1'b1;
  endtask

  task automatic set_wb(input int p, input int id, input logic [63:0] d,
                        input logic exv, input logic [63:0] cause);
    wbv[p]         = 1'b1;
    wbid[p]        = TRANS_ID_BITS'(id);
    wbd[p]         = d;
    wbex[p]        = '0;
    wbex[p].valid  = exv;
    wbex[p].cause  = cause;
  endtask

  // Compare outputs against the model, then advance the model one edge.
  task automatic cycle();
    logic want_ack;
    logic cv;
    m_t   h;
    #1;
    want_ack = dvalid && (q.size() < N) && !flush;
    chk("ack", 64'(ack), 64'(want_ack));
    chk("full", 64'(full), 64'(q.size() == N));
    chk("issued_id", 64'(issued), 64'(next_id));
    cv = 1'b0;
    h  = '0;
    if (q.size() > 0) begin
      h = q[0];
`ifdef SB_COMMIT_BYPASS_EN
      for (int p = 0; p < P; p++) begin
        if (wbv[p] && wbid[p] == h.id) begin
          h.result = wbd[p];
          h.done   = 1'b1;
          if (wbex[p].valid) begin
            h.exv   = 1'b1;
            h.cause = wbex[p].cause;
          end
        end
      end
`endif
      cv = h.done;
    end
    chk("commit_valid", 64'(cvalid), 64'(cv));
    if (cv) begin
      chk("head_id", 64'(cinstr.trans_id), 64'(h.id));
      chk("head_pc", cinstr.pc, h.pc);
      chk("head_result", cinstr.result, h.result);
      chk("head_exv", 64'(cinstr.ex.valid), 64'(h.exv));
      if (h.exv)
        chk("head_cause", cinstr.ex.cause, h.cause);
    end
    @(posedge clk);
    if (flush) begin
      q.delete();
      next_id = 0;
    end else begin
      for (int p = 0; p < P; p++) begin
        if (wbv[p]) begin
          for (int i = 0; i < q.size(); i++) begin
            if (q[i].id == wbid[p]) begin
              q[i].result = wbd[p];
              q[i].done   = 1'b1;
              if (wbex[p].valid) begin
                q[i].exv   = 1'b1;
                q[i].cause = wbex[p].cause;
              end
            end
          end
        end
      end
      if (cack && cv)
        void'(q.pop_front());
      if (want_ack) begin
        q.push_back('{id: 2'(next_id), done: dinstr.ex.valid,
                      result: dinstr.result, pc: dinstr.pc,
                      cause: dinstr.ex.cause, exv: dinstr.ex.valid});
        next_id = (next_id + 1) % N;
      end
    end
    #1;
  endtask

  initial begin
    int prev;
    int acks;
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (cinstr === '0) else begin
      failures++;
      $error("FAIL reset_commit_instr observed=%0h expected=0", cinstr);
    end
    chk("reset_full", 64'(full), 64'd0);
    chk("reset_cvalid", 64'(cvalid), 64'd0);
    chk("reset_issued", 64'(issued), 64'd0);
    rst     = 1'b0;
    q.delete();
    next_id = 0;

    // Fill with no writeback, then a fifth offer is refused.
    for (int i = 0; i < 4; i++) begin
      chk("fill_id", 64'(issued), 64'(i));
      set_issue(64'h1000 + 64'(4 * i), 1'b0, 64'd0);
      cycle();
      idle();
    end
    chk("fill_full", 64'(full), 64'd1);
    set_issue(64'h2000, 1'b0, 64'd0);
    #1;
    chk("fifth_ack", 64'(ack), 64'd0);
    cycle();
    idle();

    // Out-of-order writeback, in-order retire.
    set_wb(0, 2, 64'hDEAD, 1'b0, 64'd0);
    cycle();
    idle();
    chk("ooo_cvalid", 64'(cvalid), 64'd0);
    set_wb(0, 0, 64'h1111, 1'b0, 64'd0);
    cycle();
    idle();
    set_wb(1, 1, 64'h2222, 1'b0, 64'd0);
    cycle();
    idle();
    cack = 1'b1;
    cycle();
    cycle();
    #1;
    chk("slot2_result", cinstr.result, 64'hDEAD);
    cycle();
    idle();
    set_wb(0, 3, 64'h3333, 1'b0, 64'd0);
    cack = 1'b1;
    cycle();
    cycle();
    idle();

    // Both ports hit slot 1: port 1 wins.
    set_issue(64'h3000, 1'b0, 64'd0);
    cycle();
    set_issue(64'h3004, 1'b0, 64'd0);
    cycle();
    idle();
    set_wb(0, 1, 64'hA, 1'b0, 64'd0);
    set_wb(1, 1, 64'hB, 1'b0, 64'd0);
    cycle();
    idle();
    set_wb(0, 0, 64'h5, 1'b0, 64'd0);
    cycle();
    idle();
    cack = 1'b1;
    cycle();
    #1;
    chk("prio_result", cinstr.result, 64'hB);
    cycle();
    idle();

    // Fetch exception finishes the entry at issue.
    set_issue(64'h4000, 1'b1, ILLEGAL_INSTR);
    cycle();
    idle();
    #1;
    chk("exc_cvalid", 64'(cvalid), 64'd1);
    chk("exc_cause", cinstr.ex.cause, 64'd2);
    cack = 1'b1;
    cycle();
    idle();

    // Flush a full buffer while decode and a writeback are active.
    for (int i = 0; i < 4; i++) begin
      set_issue(64'h5000 + 64'(4 * i), 1'b0, 64'd0);
      cycle();
    end
    idle();
    flush = 1'b1;
    set_issue(64'h6000, 1'b0, 64'd0);
    set_wb(0, 0, 64'h77, 1'b0, 64'd0);
    #1;
    chk("flush_ack", 64'(ack), 64'd0);
    cycle();
    idle();
    #1;
    chk("flush_full", 64'(full), 64'd0);
    chk("flush_cvalid", 64'(cvalid), 64'd0);
    chk("flush_next_id", 64'(issued), 64'd0);
    set_issue(64'h6100, 1'b0, 64'd0);
    cycle();
    idle();
    set_wb(0, 0, 64'h88, 1'b0, 64'd0);
    cycle();
    idle();
    cack = 1'b1;
    cycle();
    idle();

    // Back-to-back issue/writeback/commit across the wrap.
    acks = 0;
    prev = -1;
    for (int i = 0; i < 10; i++) begin
      idle();
      chk("wrap_id", 64'(issued), 64'((i + 1) % N));
      set_issue(64'h7000 + 64'(4 * i), 1'b0, 64'd0);
      if (prev >= 0)
        set_wb(i % 2, prev, 64'(i) + 64'h100, 1'b0, 64'd0);
      cack = 1'b1;
      #1;
      if (ack)
        acks++;
      prev = int'(issued);
      cycle();
    end
    chk("wrap_no_stall", 64'(acks), 64'd10);
    idle();
    set_wb(0, prev, 64'h999, 1'b0, 64'd0);
    cack = 1'b1;
    cycle();
    idle();
    repeat (4) begin
      cack = 1'b1;
      cycle();
    end
    idle();

    // Random traffic.
    for (int k = 0; k < 500; k++) begin
      idle();
      if ($urandom_range(0, 1) == 1)
        set_issue({$urandom, $urandom}, $urandom_range(0, 9) == 0,
                  64'($urandom_range(0, 7)));
      for (int p = 0; p < P; p++)
        if ($urandom_range(0, 2) != 0)
          set_wb(p, int'($urandom_range(0, N - 1)), {$urandom, $urandom},
                 $urandom_range(0, 7) == 0, 64'($urandom_range(0, 7)));
      cack  = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
